// File: rtl/debounce_pkg.sv
// Shared constants, helpers and types for the debounce_array pin-conditioning block.
// Used by debounce_channel and debounce_array.
package debounce_pkg;

    localparam int DEF_STABLE_CYC  = 100000;
    localparam int DEF_SYNC_STAGES = 2;

    // Counter width that never collapses to zero bits for tiny counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic rise;
        logic fall;
    } edge_t;

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser chain, candidate/stability counter, level and edge strobes.
// Level and strobes are all registered and update on the same clock edge.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYC  = DEF_STABLE_CYC,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk_100mhz,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int               CNT_W   = clog2_min1(STABLE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_cand;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    edge_t                  r_edge;

    logic  w_raw_s;
    logic  w_stable;
    logic  w_level_next;
    edge_t w_edge_next;

    assign w_raw_s  = r_sync[SYNC_STAGES-1];
    assign w_stable = (w_raw_s == r_cand) && (r_cnt == CNT_MAX);

    // The level only follows the candidate once the counter has saturated.
    assign w_level_next     = w_stable ? r_cand : r_level;
    assign w_edge_next.rise = w_level_next & ~r_level;
    assign w_edge_next.fall = ~w_level_next & r_level;

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_cand  <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_edge  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
            if (w_raw_s != r_cand) begin
                r_cand <= w_raw_s;
                r_cnt  <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_level <= w_level_next;
            r_edge  <= w_edge_next;
        end
    end

    assign level = r_level;
    assign rise  = r_edge.rise;
    assign fall  = r_edge.fall;

endmodule

// File: rtl/debounce_array.sv
// Debouncer for N_BTN buttons and N_SW switches with press/release strobes, switch-change strobe and reset request.
// Optional auto-repeat on held buttons is enabled by defining AUTO_REPEAT_EN.
module debounce_array
    import debounce_pkg::*;
#(
    parameter int N_BTN         = 5,
    parameter int N_SW          = 8,
    parameter int STABLE_CYC    = 100000,
    parameter int SYNC_STAGES   = 2,
    parameter int RST_BTN_IDX   = 2,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic             clk_100mhz,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] button,
    input  logic [N_SW-1:0]  SW,
    output logic [N_BTN-1:0] button_out,
    output logic [N_BTN-1:0] button_pulse,
    output logic [N_BTN-1:0] button_release,
    output logic [N_SW-1:0]  SW_OK,
    output logic             sw_change,
    output logic             rst
);

    logic [N_BTN-1:0] w_btn_level;
    logic [N_BTN-1:0] w_btn_rise;
    logic [N_BTN-1:0] w_btn_fall;
    logic [N_SW-1:0]  w_sw_level;
    logic [N_SW-1:0]  w_sw_rise;
    logic [N_SW-1:0]  w_sw_fall;
    logic             r_rst;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        debounce_channel #(
            .STABLE_CYC (STABLE_CYC),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_chan (
            .clk_100mhz(clk_100mhz),
            .rst_n     (rst_n),
            .din       (button[gi]),
            .level     (w_btn_level[gi]),
            .rise      (w_btn_rise[gi]),
            .fall      (w_btn_fall[gi])
        );
    end

    for (genvar gi = 0; gi < N_SW; gi++) begin : g_sw
        debounce_channel #(
            .STABLE_CYC (STABLE_CYC),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_chan (
            .clk_100mhz(clk_100mhz),
            .rst_n     (rst_n),
            .din       (SW[gi]),
            .level     (w_sw_level[gi]),
            .rise      (w_sw_rise[gi]),
            .fall      (w_sw_fall[gi])
        );
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_rst <= 1'b0;
        end else begin
            r_rst <= w_btn_level[RST_BTN_IDX];
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int               REP_W      = clog2_min1(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_FIRE   = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_rep
        logic [REP_W-1:0] r_rep_cnt;
        logic             r_rep_pulse;

        // r_rep_cnt holds the number of cycles since the press strobe; reload restarts the period.
        always_ff @(posedge clk_100mhz or negedge rst_n) begin
            if (!rst_n) begin
                r_rep_cnt   <= '0;
                r_rep_pulse <= 1'b0;
            end else begin
                r_rep_pulse <= w_btn_level[gi] & ~w_btn_rise[gi] & (r_rep_cnt == REP_FIRE);
                if (!w_btn_level[gi]) begin
                    r_rep_cnt <= '0;
                end else if (w_btn_rise[gi]) begin
                    r_rep_cnt <= REP_W'(1);
                end else if (r_rep_cnt == REP_FIRE) begin
                    r_rep_cnt <= REP_RELOAD;
                end else begin
                    r_rep_cnt <= r_rep_cnt + REP_W'(1);
                end
            end
        end

        // A repeat that lands on the release edge is suppressed by the now-low level.
        assign button_pulse[gi] = w_btn_rise[gi] | (r_rep_pulse & w_btn_level[gi]);
    end
`else
    assign button_pulse = w_btn_rise;
`endif

    assign button_out     = w_btn_level;
    assign button_release = w_btn_fall;
    assign SW_OK          = w_sw_level;
    // Strobes are registered together with SW_OK, so this OR rises exactly on the SW_OK update.
    assign sw_change      = |(w_sw_rise | w_sw_fall);
    assign rst            = r_rst;

endmodule
